lcd_text_buffer: RTL

Two-row character frame buffer feeding the HD44780-style `lcd` controller on the PMOD LCD. EDSAC-side logic writes ASCII characters at (row, column) positions at any time. Whenever the buffer changes, the block streams a full refresh frame (DDRAM address commands plus characters) to the `lcd` controller's byte input through a valid/ready handshake.

---
 rtl/lcd_pkg.sv | 16 +
 rtl/lcd_char_ram.sv | 31 +++
 rtl/lcd_text_buffer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Constants and FSM state type shared by the LCD text buffer and the lcd controller.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_LINE0 = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE1 = 8'hC0;
    localparam logic [7:0] LCD_BLANK     = 8'h20;

    typedef enum logic [2:0] {
        StIdle,
        StAddr0,
        StRow0,
        StAddr1,
        StRow1
    } lcd_state_e;

endpackage

// File: rtl/lcd_char_ram.sv
// Character storage: reset-initialised register array, one write port, one combinational read.
module lcd_char_ram
    import lcd_pkg::*;
#(
    parameter int unsigned Depth = 32,
    parameter int unsigned AW    = $clog2(Depth)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [Depth];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= LCD_BLANK;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lcd_text_buffer.sv
// Two-row LCD frame buffer; streams a full refresh frame (address commands plus characters)
// over a valid/ready byte interface whenever the buffer is dirty.
module lcd_text_buffer
    import lcd_pkg::*;
#(
    parameter int unsigned COLS = 16,
    parameter int unsigned AW   = $clog2(2 * COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_char,
    input  logic          refresh,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_rs,
    output logic [7:0]    out_byte,
    output logic          busy,
    output logic          frame_done
);

    localparam int unsigned Entries = 2 * COLS;
    localparam int unsigned CW      = (COLS > 1) ? $clog2(COLS) : 1;

    lcd_state_e    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic          dirty_q, dirty_d;
    logic          valid_q, valid_d;
    logic          rs_q, rs_d;
    logic [7:0]    byte_q, byte_d;
    logic          done_q, done_d;

    logic          addr_ok;
    logic          wr_ok;
    logic          xfer;
    logic          clear_dirty;
    logic          rd_row;
    logic [CW-1:0] rd_col;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    // When the address space is exactly filled every address is valid.
    if (Entries == (1 << AW)) begin : g_full_range
        assign addr_ok = 1'b1;
    end else begin : g_part_range
        assign addr_ok = ({1'b0, wr_addr} < (AW + 1)'(Entries));
    end

    assign wr_ok = wr_en & addr_ok;
    assign xfer  = valid_q & out_ready;

    lcd_char_ram #(
        .Depth (Entries),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (wr_ok),
        .waddr_i (wr_addr),
        .wdata_i (wr_char),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Entry that the next transfer in the current state would load.
    always_comb begin
        rd_row  = (state_q == StAddr1) || (state_q == StRow1);
        rd_col  = ((state_q == StRow0) || (state_q == StRow1)) ? col_q + CW'(1) : '0;
        rd_addr = rd_row ? AW'(COLS) + AW'(rd_col) : AW'(rd_col);
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        valid_d     = valid_q;
        rs_d        = rs_q;
        byte_d      = byte_q;
        done_d      = 1'b0;
        clear_dirty = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (dirty_q) begin
                    state_d     = StAddr0;
                    valid_d     = 1'b1;
                    rs_d        = 1'b0;
                    byte_d      = LCD_CMD_LINE0;
                    clear_dirty = 1'b1;
                end
            end
            StAddr0, StAddr1: begin
                if (xfer) begin
                    state_d = (state_q == StAddr0) ? StRow0 : StRow1;
                    col_d   = '0;
                    rs_d    = 1'b1;
                    byte_d  = rd_data;
                end
            end
            StRow0: begin
                if (xfer) begin
                    if (col_q == CW'(COLS - 1)) begin
                        state_d = StAddr1;
                        rs_d    = 1'b0;
                        byte_d  = LCD_CMD_LINE1;
                    end else begin
                        col_d  = col_q + CW'(1);
                        byte_d = rd_data;
                    end
                end
            end
            StRow1: begin
                if (xfer) begin
                    if (col_q == CW'(COLS - 1)) begin
                        done_d = 1'b1;
                        if (dirty_q) begin
                            state_d     = StAddr0;
                            rs_d        = 1'b0;
                            byte_d      = LCD_CMD_LINE0;
                            clear_dirty = 1'b1;
                        end else begin
                            state_d = StIdle;
                            valid_d = 1'b0;
                        end
                    end else begin
                        col_d  = col_q + CW'(1);
                        byte_d = rd_data;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase

        // A new write or refresh in the frame-start cycle must still request another frame.
        if (wr_ok || refresh) begin
            dirty_d = 1'b1;
        end else if (clear_dirty) begin
            dirty_d = 1'b0;
        end else begin
            dirty_d = dirty_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            dirty_q <= 1'b0;
            valid_q <= 1'b0;
            rs_q    <= 1'b0;
            byte_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            dirty_q <= dirty_d;
            valid_q <= valid_d;
            rs_q    <= rs_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_rs     = rs_q;
    assign out_byte   = byte_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = done_q;

endmodule
